operand_net_bypass_s: RTL and testbench

Parametrised scalar-unit operand network, successor to the fixed 4-port, 3-operand router.
- Routes NUM_RF_PORTS register-file read ports onto NUM_OPERANDS ALU operands.
- Forwards in-flight writebacks from an integrated CAM bypass buffer with explicit commit and flush.
- Drives a registered operand stage, stall-held, into the scalar execution units and the PAC unit.

---
 rtl/pkg_tpu.sv | 18 +
 rtl/operand_net_bypass_s_cam.sv | 108 ++++++++++
 rtl/operand_net_bypass_s.sv | 122 ++++++++++++
 tb/tb_operand_net_bypass_s.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkg_tpu.sv
// Shared scalar-unit types for the operand network and its bypass CAM.
// Entry layout is {valid, idx, data}.
package pkg_tpu;

  localparam int DATA_W           = 32;
  localparam int INDEX_W          = 8;
  localparam int BYPASS_BUFF_SIZE = 4;

  typedef logic [DATA_W-1:0]  data_t;
  typedef logic [INDEX_W-1:0] index_t;

  typedef struct packed {
    logic   valid;
    index_t idx;
    data_t  data;
  } bypass_entry_t;

endpackage

// File: rtl/operand_net_bypass_s_cam.sv
// Bypass CAM: circular buffer of in-flight writebacks with commit/flush.
// BYPASS_WB_FWD_EN adds same-cycle writeback forwarding to the match ports.
module bypass_cam_s
  import pkg_tpu::*;
#(
  parameter int DEPTH = BYPASS_BUFF_SIZE,
  parameter int NOPS  = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 wb_valid,
  input  index_t               wb_idx,
  input  data_t                wb_data,
  input  logic                 commit,
  input  index_t [NOPS-1:0]    lk_idx,
  output logic   [NOPS-1:0]    lk_hit,
  output data_t  [NOPS-1:0]    lk_data,
  output logic                 full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  bypass_entry_t [DEPTH-1:0] ent_q, ent_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wb_ok;
  logic          wb_hit;
  logic [PW-1:0] wb_pos;
  logic          com;
  logic          alloc;

  assign full = (cnt_q == CW'(DEPTH));

  always_comb begin
    ent_d  = ent_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    wb_hit = 1'b0;
    wb_pos = '0;
    wb_ok  = wb_valid && (wb_idx != '0);
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_q[i].valid && ent_q[i].idx == wb_idx) begin
        wb_hit = 1'b1;
        wb_pos = PW'(i);
      end
    end
    com   = commit && (cnt_q != '0);
    alloc = wb_ok && !wb_hit && (!full || com);
    if (wb_ok && wb_hit) begin
      ent_d[wb_pos].data = wb_data;
    end
    if (com) begin
      ent_d[rd_q].valid = 1'b0;
      rd_d = rd_q + 1'b1;
    end
    // When full, the slot being allocated is the one just retired.
    if (alloc) begin
      ent_d[wr_q] = '{valid: 1'b1, idx: wb_idx, data: wb_data};
      wr_d = wr_q + 1'b1;
    end
    cnt_d = cnt_q + CW'(alloc) - CW'(com);
    if (flush) begin
      ent_d = '0;
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end
  end

  always_comb begin
    lk_hit  = '0;
    lk_data = '0;
    for (int k = 0; k < NOPS; k++) begin
      if (lk_idx[k] != '0) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (ent_q[i].valid && ent_q[i].idx == lk_idx[k]) begin
            lk_hit[k]  = 1'b1;
            lk_data[k] = ent_q[i].data;
          end
        end
`ifdef BYPASS_WB_FWD_EN
        if (wb_ok && wb_idx == lk_idx[k]) begin
          lk_hit[k]  = 1'b1;
          lk_data[k] = wb_data;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      ent_q <= ent_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/operand_net_bypass_s.sv
// Operand network: RF port muxes, bypass CAM lookup, stall-held output stage.
// Define BYPASS_WB_FWD_EN for same-cycle writeback forwarding.
module operand_net_bypass_s
  import pkg_tpu::*;
#(
  parameter int NUM_RF_PORTS = 4,
  parameter int NUM_OPERANDS = 3,
  parameter int DATA_WIDTH   = 32,
  parameter int INDEX_WIDTH  = 8,
  parameter int BYPASS_DEPTH = BYPASS_BUFF_SIZE,
  parameter int WIDTH_SEL    = $clog2(NUM_RF_PORTS)
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                I_Stall,
  input  logic                                I_Req,
  input  logic                                I_Flush,
  input  logic [NUM_OPERANDS*WIDTH_SEL-1:0]   I_Sel_Path,
  input  logic [NUM_OPERANDS-1:0]             I_Sel_Src,
  input  logic [NUM_RF_PORTS*DATA_WIDTH-1:0]  I_Src_Data,
  input  logic [NUM_RF_PORTS*INDEX_WIDTH-1:0] I_Src_Idx,
  input  logic                                I_WB_Valid,
  input  logic [INDEX_WIDTH-1:0]              I_WB_DstIdx,
  input  logic [DATA_WIDTH-1:0]               I_WB_Data,
  input  logic                                I_WB_Commit,
  output logic                                O_Valid,
  output logic [NUM_OPERANDS*DATA_WIDTH-1:0]  O_Src_Data,
  output logic [NUM_OPERANDS-1:0]             O_Src_Hit,
  output logic                                O_Buff_Full,
  output logic [DATA_WIDTH-1:0]               O_PAC_Src_Data
);

  logic [NUM_OPERANDS-1:0][INDEX_WIDTH-1:0] op_idx;
  logic [NUM_OPERANDS-1:0][DATA_WIDTH-1:0]  rf_data;
  logic [NUM_OPERANDS-1:0][DATA_WIDTH-1:0]  res;
  data_t [NUM_OPERANDS-1:0]                 cam_data;
  logic [NUM_OPERANDS-1:0]                  cam_hit;
  logic [DATA_WIDTH-1:0]                    pac_raw;
  int                                       sel;
  int                                       pac_sel;
  logic                                     act;

  logic                                     valid_q, valid_d;
  logic [NUM_OPERANDS*DATA_WIDTH-1:0]       data_q, data_d;
  logic [NUM_OPERANDS-1:0]                  hit_q, hit_d;
  logic [DATA_WIDTH-1:0]                    pac_q, pac_d;

  always_comb begin
    sel     = 0;
    act     = 1'b0;
    op_idx  = '0;
    rf_data = '0;
    pac_raw = '0;
    pac_sel = int'(I_Sel_Path[WIDTH_SEL-1:0]);
    if (pac_sel < NUM_RF_PORTS) begin
      pac_raw = I_Src_Data[pac_sel*DATA_WIDTH +: DATA_WIDTH];
    end
    for (int k = 0; k < NUM_OPERANDS; k++) begin
      sel = int'(I_Sel_Path[k*WIDTH_SEL +: WIDTH_SEL]);
      act = I_Req && I_Sel_Src[k] && (sel < NUM_RF_PORTS);
      if (act) begin
        op_idx[k]  = I_Src_Idx[sel*INDEX_WIDTH +: INDEX_WIDTH];
        rf_data[k] = I_Src_Data[sel*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  bypass_cam_s #(
    .DEPTH (BYPASS_DEPTH),
    .NOPS  (NUM_OPERANDS)
  ) u_cam (
    .clk      (clock),
    .rst_n    (reset),
    .flush    (I_Flush),
    .wb_valid (I_WB_Valid),
    .wb_idx   (I_WB_DstIdx),
    .wb_data  (I_WB_Data),
    .commit   (I_WB_Commit),
    .lk_idx   (op_idx),
    .lk_hit   (cam_hit),
    .lk_data  (cam_data),
    .full     (O_Buff_Full)
  );

  always_comb begin
    res = '0;
    for (int k = 0; k < NUM_OPERANDS; k++) begin
      res[k] = cam_hit[k] ? cam_data[k] : rf_data[k];
    end
  end

  // Flush kills the valid even through a stall; payload follows the stall.
  always_comb begin
    valid_d = I_Stall ? valid_q : I_Req;
    data_d  = I_Stall ? data_q  : res;
    hit_d   = I_Stall ? hit_q   : cam_hit;
    pac_d   = I_Stall ? pac_q   : pac_raw;
    if (I_Flush) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      hit_q   <= '0;
      pac_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      hit_q   <= hit_d;
      pac_q   <= pac_d;
    end
  end

  assign O_Valid        = valid_q;
  assign O_Src_Data     = data_q;
  assign O_Src_Hit      = hit_q;
  assign O_PAC_Src_Data = pac_q;

endmodule

// File: tb/tb_operand_net_bypass_s.sv
// Scoreboard bench for operand_net_bypass_s against a queue-based model.
// Honors BYPASS_WB_FWD_EN in the model when defined.
module tb_operand_net_bypass_s;

  localparam int NP = 4;
  localparam int NO = 3;
  localparam int DW = 32;
  localparam int IW = 8;
  localparam int D  = 4;
  localparam int WS = 2;
`ifdef BYPASS_WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             I_Stall;
  logic             I_Req;
  logic             I_Flush;
  logic [NO*WS-1:0] I_Sel_Path;
  logic [NO-1:0]    I_Sel_Src;
  logic [NP*DW-1:0] I_Src_Data;
  logic [NP*IW-1:0] I_Src_Idx;
  logic             I_WB_Valid;
  logic [IW-1:0]    I_WB_DstIdx;
  logic [DW-1:0]    I_WB_Data;
  logic             I_WB_Commit;
  logic             O_Valid;
  logic [NO*DW-1:0] O_Src_Data;
  logic [NO-1:0]    O_Src_Hit;
  logic             O_Buff_Full;
  logic [DW-1:0]    O_PAC_Src_Data;

  operand_net_bypass_s dut (
    .clock          (clk),
    .reset          (rst_n),
    .I_Stall        (I_Stall),
    .I_Req          (I_Req),
    .I_Flush        (I_Flush),
    .I_Sel_Path     (I_Sel_Path),
    .I_Sel_Src      (I_Sel_Src),
    .I_Src_Data     (I_Src_Data),
    .I_Src_Idx      (I_Src_Idx),
    .I_WB_Valid     (I_WB_Valid),
    .I_WB_DstIdx    (I_WB_DstIdx),
    .I_WB_Data      (I_WB_Data),
    .I_WB_Commit    (I_WB_Commit),
    .O_Valid        (O_Valid),
    .O_Src_Data     (O_Src_Data),
    .O_Src_Hit      (O_Src_Hit),
    .O_Buff_Full    (O_Buff_Full),
    .O_PAC_Src_Data (O_PAC_Src_Data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned   cyc;
    logic          v;
    logic [NO*DW-1:0] d;
    logic [NO-1:0] h;
    logic [DW-1:0] pac;
    logic          full;
  } exp_t;

  typedef struct {
    logic [IW-1:0] idx;
    logic [DW-1:0] data;
  } ment_t;

  exp_t  sb[$];
  ment_t mq[$];
  logic          m_v;
  logic [NO*DW-1:0] m_d;
  logic [NO-1:0] m_h;
  logic [DW-1:0] m_pac;
  int total = 0;
  int bad   = 0;
  int unsigned cyc_n = 0;

  initial forever begin
    @(posedge clk);
    cyc_n++;
  end

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic int find(input logic [IW-1:0] ix);
    for (int i = 0; i < mq.size(); i++) begin
      if (mq[i].idx == ix) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_v = 1'b0;
    m_d = '0;
    m_h = '0;
    m_pac = '0;
  endtask

  // Predict the outputs after the coming edge, then advance one cycle.
  task automatic step();
    logic [NO*DW-1:0] nd;
    logic [NO-1:0]    nh;
    logic [DW-1:0]    pac;
    logic [IW-1:0]    ix;
    int s, p;
    exp_t e;
    ment_t t;
    nd = '0;
    nh = '0;
    for (int k = 0; k < NO; k++) begin
      s = int'(I_Sel_Path[k*WS +: WS]);
      if (I_Req && I_Sel_Src[k]) begin
        ix = I_Src_Idx[s*IW +: IW];
        nd[k*DW +: DW] = I_Src_Data[s*DW +: DW];
        if (ix != 0) begin
          p = find(ix);
          if (p >= 0) begin
            nd[k*DW +: DW] = mq[p].data;
            nh[k] = 1'b1;
          end
          if (FWD && I_WB_Valid && I_WB_DstIdx == ix) begin
            nd[k*DW +: DW] = I_WB_Data;
            nh[k] = 1'b1;
          end
        end
      end
    end
    s = int'(I_Sel_Path[WS-1:0]);
    pac = I_Src_Data[s*DW +: DW];
    if (!I_Stall) begin
      m_v = I_Req;
      m_d = nd;
      m_h = nh;
      m_pac = pac;
    end
    if (I_Flush) begin
      m_v = 1'b0;
      mq.delete();
    end else begin
      p = (I_WB_Valid && I_WB_DstIdx != 0) ? find(I_WB_DstIdx) : -1;
      if (p >= 0) begin
        t = mq[p];
        t.data = I_WB_Data;
        mq[p] = t;
      end
      if (I_WB_Commit && mq.size() > 0) void'(mq.pop_front());
      if (I_WB_Valid && I_WB_DstIdx != 0 && p < 0) begin
        total++;
        if (mq.size() < D) begin
          t.idx = I_WB_DstIdx;
          t.data = I_WB_Data;
          mq.push_back(t);
        end else begin
          bad++;
          $display("FAIL no_drop: got alloc-while-full want none");
        end
      end
    end
    e.cyc = cyc_n + 1;
    e.v = m_v;
    e.d = m_d;
    e.h = m_h;
    e.pac = m_pac;
    e.full = (mq.size() == D);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial forever begin
    exp_t e;
    @(posedge clk);
    #3;
    while (sb.size() > 0 && sb[0].cyc <= cyc_n) begin
      e = sb.pop_front();
      chk("mon_valid", 128'(O_Valid), 128'(e.v));
      chk("mon_data", 128'(O_Src_Data), 128'(e.d));
      chk("mon_hit", 128'(O_Src_Hit), 128'(e.h));
      chk("mon_pac", 128'(O_PAC_Src_Data), 128'(e.pac));
      chk("mon_full", 128'(O_Buff_Full), 128'(e.full));
    end
  end

  task automatic clear_in();
    I_Stall = 0;
    I_Req = 0;
    I_Flush = 0;
    I_Sel_Path = '0;
    I_Sel_Src = '0;
    I_Src_Data = '0;
    I_Src_Idx = '0;
    I_WB_Valid = 0;
    I_WB_DstIdx = '0;
    I_WB_Data = '0;
    I_WB_Commit = 0;
  endtask

  task automatic set_port(input int p, input logic [IW-1:0] ix,
                          input logic [DW-1:0] d);
    I_Src_Idx[p*IW +: IW] = ix;
    I_Src_Data[p*DW +: DW] = d;
  endtask

  task automatic wb(input logic [IW-1:0] ix, input logic [DW-1:0] d);
    I_WB_Valid = 1;
    I_WB_DstIdx = ix;
    I_WB_Data = d;
  endtask

  task automatic route_setup();
    clear_in();
    set_port(0, 8'd1, 32'h11);
    set_port(1, 8'd2, 32'h22);
    set_port(2, 8'd3, 32'h33);
    set_port(3, 8'd4, 32'h44);
    I_Sel_Path = {2'd1, 2'd0, 2'd3};
    I_Sel_Src = 3'b111;
    I_Req = 1;
  endtask

  initial begin
    logic [NO*DW-1:0] route_exp;
    route_exp = {32'h22, 32'h11, 32'h44};
    clear_in();
    model_reset();
    rst_n = 0;
    #12;
    chk("rst_valid", 128'(O_Valid), 0);
    chk("rst_data", 128'(O_Src_Data), 0);
    chk("rst_hit", 128'(O_Src_Hit), 0);
    chk("rst_pac", 128'(O_PAC_Src_Data), 0);
    chk("rst_full", 128'(O_Buff_Full), 0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;

    route_setup();
    step();
    chk("route_valid", 128'(O_Valid), 1);
    chk("route_data", 128'(O_Src_Data), 128'(route_exp));
    chk("route_hit", 128'(O_Src_Hit), 0);
    chk("route_pac", 128'(O_PAC_Src_Data), 128'h44);

    clear_in();
    set_port(0, 8'd5, 32'h0);
    wb(8'd5, 32'hAAAA);
    I_Req = 1;
    I_Sel_Src = 3'b001;
    step();
    chk("fwd_same_hit", 128'(O_Src_Hit[0]), 128'(FWD));
    I_WB_Valid = 0;
    step();
    chk("fwd_next_data", 128'(O_Src_Data[31:0]), 128'hAAAA);
    chk("fwd_next_hit", 128'(O_Src_Hit[0]), 1);

    clear_in();
    wb(8'd6, 32'h1);
    step();
    wb(8'd6, 32'h2);
    step();
    I_WB_Valid = 0;
    set_port(0, 8'd6, 32'h66);
    I_Req = 1;
    I_Sel_Src = 3'b001;
    step();
    chk("inplace_data", 128'(O_Src_Data[31:0]), 128'h2);
    chk("inplace_full", 128'(O_Buff_Full), 0);

    clear_in();
    wb(8'd7, 32'h7);
    step();
    wb(8'd8, 32'h8);
    step();
    I_WB_Valid = 0;
    step();
    chk("fill_full", 128'(O_Buff_Full), 1);

    I_WB_Commit = 1;
    wb(8'd9, 32'h99);
    step();
    clear_in();
    set_port(0, 8'd5, 32'h55);
    set_port(1, 8'd9, 32'h0);
    I_Sel_Path = {2'd0, 2'd1, 2'd0};
    I_Sel_Src = 3'b011;
    I_Req = 1;
    step();
    chk("swap_full", 128'(O_Buff_Full), 1);
    chk("swap_old_lost", 128'(O_Src_Data[31:0]), 128'h55);
    chk("swap_new_hit", 128'(O_Src_Data[63:32]), 128'h99);
    chk("swap_hits", 128'(O_Src_Hit), 128'b010);

    clear_in();
    set_port(0, 8'd6, 32'h0);
    I_Req = 1;
    I_Sel_Src = 3'b001;
    step();
    for (int c = 0; c < 3; c++) begin
      I_Stall = 1;
      I_Sel_Src = 3'($urandom);
      I_Sel_Path = 6'($urandom);
      I_Src_Data = {$urandom, $urandom, $urandom, $urandom};
      I_WB_Commit = (c == 0);
      I_WB_Valid = (c == 0);
      I_WB_DstIdx = 8'd10;
      I_WB_Data = 32'hA10;
      step();
      chk("stall_data", 128'(O_Src_Data[31:0]), 128'h2);
      chk("stall_valid", 128'(O_Valid), 1);
    end
    clear_in();
    set_port(2, 8'd10, 32'h0);
    I_Sel_Path = 6'b000010;
    I_Sel_Src = 3'b001;
    I_Req = 1;
    step();
    chk("stall_wb_hit", 128'(O_Src_Data[31:0]), 128'hA10);

    clear_in();
    I_WB_Commit = 1;
    step();
    clear_in();
    I_Flush = 1;
    I_Stall = 1;
    wb(8'd11, 32'hB);
    I_Req = 1;
    I_Sel_Src = 3'b001;
    set_port(0, 8'd8, 32'h8);
    step();
    chk("flush_valid", 128'(O_Valid), 0);
    clear_in();
    set_port(0, 8'd8, 32'h88);
    I_Req = 1;
    I_Sel_Src = 3'b001;
    step();
    chk("flush_nohit", 128'(O_Src_Hit), 0);
    chk("flush_data", 128'(O_Src_Data[31:0]), 128'h88);

    clear_in();
    wb(8'd0, 32'hDEAD);
    step();
    for (int i = 1; i <= 3; i++) begin
      wb(8'(i), 32'(i));
      step();
    end
    clear_in();
    set_port(0, 8'd0, 32'h77);
    I_Req = 1;
    I_Sel_Src = 3'b001;
    step();
    chk("zero_noalloc", 128'(O_Buff_Full), 0);
    chk("zero_nohit", 128'(O_Src_Hit[0]), 0);

    for (int n = 0; n < 400; n++) begin
      I_Req = ($urandom % 4) != 0;
      I_Sel_Src = 3'($urandom);
      I_Sel_Path = 6'($urandom);
      for (int p = 0; p < NP; p++) set_port(p, 8'($urandom % 8), $urandom);
      I_WB_Valid = $urandom % 2;
      I_WB_DstIdx = 8'($urandom % 8);
      I_WB_Data = $urandom;
      I_WB_Commit = ($urandom % 3) == 0;
      I_Stall = ($urandom % 5) == 0;
      I_Flush = ($urandom % 40) == 0;
      if (I_WB_Valid && I_WB_DstIdx != 0 && find(I_WB_DstIdx) < 0 &&
          mq.size() == D) I_WB_Commit = 1;
      step();
    end

    clear_in();
    I_Flush = 1;
    step();
    clear_in();
    I_Req = 1;
    I_Sel_Src = 3'b001;
    for (int i = 0; i < 4; i++) begin
      wb(8'(21 + i), 32'(i));
      step();
    end
    I_WB_Valid = 0;
    step();
    chk("pre_rst_full", 128'(O_Buff_Full), 1);
    chk("pre_rst_valid", 128'(O_Valid), 1);
    #3;
    rst_n = 0;
    #1;
    chk("async_valid", 128'(O_Valid), 0);
    chk("async_data", 128'(O_Src_Data), 0);
    chk("async_hit", 128'(O_Src_Hit), 0);
    chk("async_pac", 128'(O_PAC_Src_Data), 0);
    chk("async_full", 128'(O_Buff_Full), 0);
    model_reset();
    clear_in();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    route_setup();
    step();
    chk("post_rst_route", 128'(O_Src_Data), 128'(route_exp));
    clear_in();
    step();

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    #4;
    chk("sb_drained", 128'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
